// File: rtl/regfile_pkg.sv
// Shared constants for the multiport register file: write modes and loader FSM states.
package regfile_pkg;

  localparam logic [2:0] WM_WORD  = 3'd0;
  localparam logic [2:0] WM_HALF  = 3'd1;
  localparam logic [2:0] WM_BYTE  = 3'd2;
  localparam logic [2:0] WM_HALFU = 3'd3;
  localparam logic [2:0] WM_BYTEU = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_wext.sv
// Write-data extender: turns raw load/ALU data into a full-width register value.
// Reserved modes report valid=0 so the caller drops the write.
module regfile_wext
  import regfile_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      wmode,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] wext,
  output logic            valid
);

  // Decode the mode; size casts do the sign/zero fill to XLEN.
  always_comb begin
    wext  = '0;
    valid = 1'b1;
    case (wmode)
      WM_WORD:  wext = wdata;
      WM_HALF:  wext = XLEN'($signed(wdata[15:0]));
      WM_BYTE:  wext = XLEN'($signed(wdata[7:0]));
      WM_HALFU: wext = XLEN'(wdata[15:0]);
      WM_BYTEU: wext = XLEN'(wdata[7:0]);
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: NRD registered read ports with write-first forwarding,
// one extending write port, a one-register-per-cycle bulk image loader and a
// flat snapshot of the live contents. Register 0 reads as zero.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [2:0]            wmode,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*XLEN-1:0]   rdata,
  input  logic                  load_start,
  input  logic [NREGS*XLEN-1:0] load_image,
  output logic                  busy,
  output logic                  load_done,
  output logic [NREGS*XLEN-1:0] snapshot
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0][XLEN-1:0] img;
  logic [NRD-1:0][AW-1:0]     ra;
  logic [NRD-1:0][XLEN-1:0]   rd_q;
  logic [AW-1:0]              idx;
  logic [XLEN-1:0]            wext;
  logic                       wvalid;
  logic                       wr_acc;
  logic                       idle;
  state_t                     state, state_nxt;

  assign img   = load_image;
  assign ra    = raddr;
  assign rdata = rd_q;
  assign idle  = (state == S_IDLE);

  // A load request in the same cycle wins over a normal write.
  assign wr_acc = we && wvalid && idle && !load_start && (waddr != '0);

  assign busy      = (state == S_LOAD);
  assign load_done = (state == S_DONE);

  regfile_wext #(.XLEN(XLEN)) u_wext (
    .wmode (wmode),
    .wdata (wdata),
    .wext  (wext),
    .valid (wvalid)
  );

  // Loader state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Loader next state: IDLE -> LOAD on request, LOAD until the top index, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load_start) state_nxt = S_LOAD;
      S_LOAD:  if (idx == AW'(NREGS-1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load index: starts at 1 since register 0 is never loaded.
  always_ff @(posedge clk) begin
    if (reset)                   idx <= '0;
    else if (idle && load_start) idx <= AW'(1);
    else if (state == S_LOAD)    idx <= idx + AW'(1);
  end

  // Register array: image loader has the port while loading, else the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (state == S_LOAD) begin
      if (idx != '0) regs[idx] <= img[idx];
    end else if (wr_acc) begin
      regs[waddr] <= wext;
    end
  end

  // Read ports: update only in IDLE, forward a same-cycle accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (idle) begin
      for (int k = 0; k < NRD; k++) begin
        if (ra[k] == '0)                    rd_q[k] <= '0;
        else if (wr_acc && waddr == ra[k])  rd_q[k] <= wext;
        else                                rd_q[k] <= regs[ra[k]];
      end
    end
  end

  // Snapshot of live contents; slice 0 tied to zero so its flops can be pruned.
  always_comb begin
    snapshot             = regs;
    snapshot[XLEN-1:0]   = '0;
  end

endmodule
